// File: rtl/lock_arbiter.sv
// lock_arbiter -- hardware lock arbitration between the two cores.
//
// Each core presents one request at a time: op=1 acquires (afl), op=0
// releases (nml) the lock selected by cN_id. An acquire of a lock that is
// owned by the other core parks the requesting core in WAIT until the lock
// frees. If both cores acquire the same free lock in the same cycle, the
// round-robin pointer picks the winner and then points at the loser.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cN_req/cN_op/cN_id         core N request, held stable until cN_ack
//   cN_ack/cN_err              registered one-cycle completion / error pulse
//   lock_held[i]               lock i is currently owned
//   lock_owner[i]              owning core of lock i (0 when free)
//   lock_timeout[i]            (LOCK_TIMEOUT_EN only) lock i force-released
//
// Optional feature: define LOCK_TIMEOUT_EN to add a per-lock watchdog that
// force-releases a lock after TIMEOUT cycles of the other core waiting on it.
module lock_arbiter #(
  parameter int NUM_LOCKS = 4,
  parameter int LOCK_ID_W = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 c0_req,
  input  logic                 c0_op,
  input  logic [LOCK_ID_W-1:0] c0_id,
  output logic                 c0_ack,
  output logic                 c0_err,
  input  logic                 c1_req,
  input  logic                 c1_op,
  input  logic [LOCK_ID_W-1:0] c1_id,
  output logic                 c1_ack,
  output logic                 c1_err,
  output logic [NUM_LOCKS-1:0] lock_held,
  output logic [NUM_LOCKS-1:0] lock_owner
`ifdef LOCK_TIMEOUT_EN
  ,
  output logic [NUM_LOCKS-1:0] lock_timeout
`endif
);

  if ((1 << LOCK_ID_W) < NUM_LOCKS || TIMEOUT < 1) begin : g_bad_params
    $error("lock_arbiter: LOCK_ID_W too narrow for NUM_LOCKS, or TIMEOUT < 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t               state_q [2];
  state_t               state_d [2];
  logic   [1:0]         ack_q, ack_d;
  logic   [1:0]         err_q, err_d;
  logic [NUM_LOCKS-1:0] held_q, held_d;
  logic [NUM_LOCKS-1:0] owner_q, owner_d;
  logic                 rr_q, rr_d;

  // Per-core views of the request ports so both cores share one code path.
  logic   [1:0]         req_a;
  logic   [1:0]         op_a;
  logic [LOCK_ID_W-1:0] id_a [2];
  logic   [1:0]         oor;
  logic   [1:0]         active;
  logic   [1:0]         acq;
  logic                 contend;

  assign req_a   = {c1_req, c0_req};
  assign op_a    = {c1_op,  c0_op};
  assign id_a[0] = c0_id;
  assign id_a[1] = c1_id;

  // Out-of-range ids only exist when the id space is larger than NUM_LOCKS.
  if ((1 << LOCK_ID_W) > NUM_LOCKS) begin : g_oor
    assign oor[0] = (32'(c0_id) >= NUM_LOCKS);
    assign oor[1] = (32'(c1_id) >= NUM_LOCKS);
  end else begin : g_no_oor
    assign oor = 2'b00;
  end

`ifdef LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q [NUM_LOCKS];
  logic [CNT_W-1:0] cnt_d [NUM_LOCKS];
  logic [NUM_LOCKS-1:0] to_q, to_d;
  logic             oth;
`endif

  always_comb begin
    held_d  = held_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    ack_d   = 2'b00;
    err_d   = 2'b00;
    for (int c = 0; c < 2; c++) begin
      state_d[c] = state_q[c];
      // A core evaluates when it presents a fresh request or is waiting.
      active[c]  = (state_q[c] == S_IDLE && req_a[c]) || state_q[c] == S_WAIT;
      acq[c]     = active[c] && op_a[c] && !oor[c];
    end
    // Same free lock requested by both cores in one cycle: rr_q decides.
    contend = acq[0] && acq[1] && (id_a[0] == id_a[1]) && !held_q[id_a[0]];

    for (int c = 0; c < 2; c++) begin
      if (state_q[c] == S_ACK) begin
        state_d[c] = S_IDLE;
      end else if (active[c]) begin
        if (oor[c]) begin
          state_d[c] = S_ACK;
          ack_d[c]   = 1'b1;
          err_d[c]   = 1'b1;
        end else if (op_a[c]) begin
          if (held_q[id_a[c]]) begin
            if (owner_q[id_a[c]] == c[0]) begin
              // Re-acquire by the owner is refused.
              state_d[c] = S_ACK;
              ack_d[c]   = 1'b1;
              err_d[c]   = 1'b1;
            end else begin
              state_d[c] = S_WAIT;
            end
          end else if (!contend || rr_q == c[0]) begin
            held_d[id_a[c]]  = 1'b1;
            owner_d[id_a[c]] = c[0];
            state_d[c]       = S_ACK;
            ack_d[c]         = 1'b1;
          end else begin
            state_d[c] = S_WAIT;
          end
        end else begin
          state_d[c] = S_ACK;
          ack_d[c]   = 1'b1;
          if (held_q[id_a[c]] && owner_q[id_a[c]] == c[0]) begin
            held_d[id_a[c]]  = 1'b0;
            owner_d[id_a[c]] = 1'b0;
          end else begin
            err_d[c] = 1'b1;
          end
        end
      end
    end
    if (contend) begin
      rr_d = ~rr_q;
    end

`ifdef LOCK_TIMEOUT_EN
    oth = 1'b0;
    for (int i = 0; i < NUM_LOCKS; i++) begin
      to_d[i]  = 1'b0;
      cnt_d[i] = '0;
      oth      = ~owner_q[i];
      // Count only while the lock stays held across this edge (an owner
      // release on the same edge takes precedence over the watchdog).
      if (held_q[i] && held_d[i] && state_q[oth] == S_WAIT &&
          32'(id_a[oth]) == i) begin
        if (cnt_q[i] == CNT_W'(TIMEOUT - 1)) begin
          held_d[i]  = 1'b0;
          owner_d[i] = 1'b0;
          to_d[i]    = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= S_IDLE;
      end
      ack_q   <= 2'b00;
      err_q   <= 2'b00;
      held_q  <= '0;
      owner_q <= '0;
      rr_q    <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= state_d[c];
      end
      ack_q   <= ack_d;
      err_q   <= err_d;
      held_q  <= held_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

`ifdef LOCK_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LOCKS; i++) begin
        cnt_q[i] <= '0;
      end
      to_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LOCKS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      to_q <= to_d;
    end
  end

  assign lock_timeout = to_q;
`endif

  assign c0_ack     = ack_q[0];
  assign c0_err     = err_q[0];
  assign c1_ack     = ack_q[1];
  assign c1_err     = err_q[1];
  assign lock_held  = held_q;
  assign lock_owner = owner_q;

endmodule

// File: tb/tb_lock_arbiter.sv
// Bench for lock_arbiter: directed transactions per core, a transaction-level
// model of lock ownership checked against the DUT on every falling edge, and
// literal expectations for the scenarios of interest.
module tb_lock_arbiter;

  localparam int NL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       c0_req, c0_op, c1_req, c1_op;
  logic [1:0] c0_id, c1_id;
  logic       c0_ack, c0_err, c1_ack, c1_err;
  logic [3:0] lock_held, lock_owner;
`ifdef LOCK_TIMEOUT_EN
  logic [3:0] lock_timeout;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  lock_arbiter #(.NUM_LOCKS(4), .LOCK_ID_W(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_req(c0_req), .c0_op(c0_op), .c0_id(c0_id), .c0_ack(c0_ack), .c0_err(c0_err),
    .c1_req(c1_req), .c1_op(c1_op), .c1_id(c1_id), .c1_ack(c1_ack), .c1_err(c1_err),
    .lock_held(lock_held), .lock_owner(lock_owner)
`ifdef LOCK_TIMEOUT_EN
    , .lock_timeout(lock_timeout)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // own_m[i] = owning core of lock i, -1 when free.
  // ph_m[c]  = 0 ready, 1 blocked waiting, 2 acknowledging this cycle.
  int   own_m [NL];
  int   ph_m  [2];
  int   cnt_m [NL];
  int   rr_m;
  logic m_ack [2];
  logic m_err [2];
  logic [3:0] m_to;

  function automatic logic in_req(input int c); return c == 0 ? c0_req : c1_req; endfunction
  function automatic logic in_op(input int c);  return c == 0 ? c0_op  : c1_op;  endfunction
  function automatic int   in_id(input int c);  return c == 0 ? int'(c0_id) : int'(c1_id); endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) begin own_m[i] = -1; cnt_m[i] = 0; end
      for (int c = 0; c < 2; c++) begin ph_m[c] = 0; m_ack[c] = 0; m_err[c] = 0; end
      rr_m = 0;
      m_to = '0;
    end else begin : step
      int pre_own [NL];
      int pre_ph  [2];
      bit part    [2];
      bit wants   [2];
      bit contest;
      for (int i = 0; i < NL; i++) pre_own[i] = own_m[i];
      for (int c = 0; c < 2; c++) begin
        pre_ph[c] = ph_m[c];
        part[c]   = (ph_m[c] == 0 && in_req(c)) || ph_m[c] == 1;
        wants[c]  = part[c] && in_op(c) && in_id(c) < NL;
        m_ack[c]  = 0;
        m_err[c]  = 0;
      end
      m_to    = '0;
      contest = wants[0] && wants[1] && in_id(0) == in_id(1) && pre_own[in_id(0)] == -1;
      for (int c = 0; c < 2; c++) begin
        if (pre_ph[c] == 2) ph_m[c] = 0;
        else if (part[c]) begin
          if (in_id(c) >= NL) begin ph_m[c] = 2; m_ack[c] = 1; m_err[c] = 1; end
          else if (in_op(c)) begin
            if (pre_own[in_id(c)] == c) begin ph_m[c] = 2; m_ack[c] = 1; m_err[c] = 1; end
            else if (pre_own[in_id(c)] >= 0) ph_m[c] = 1;
            else if (contest && rr_m != c) ph_m[c] = 1;
            else begin own_m[in_id(c)] = c; ph_m[c] = 2; m_ack[c] = 1; end
          end else begin
            ph_m[c] = 2; m_ack[c] = 1;
            if (pre_own[in_id(c)] == c) own_m[in_id(c)] = -1;
            else m_err[c] = 1;
          end
        end
      end
      if (contest) rr_m = 1 - rr_m;
`ifdef LOCK_TIMEOUT_EN
      for (int i = 0; i < NL; i++) begin
        int o;
        o = 1 - pre_own[i];
        if (pre_own[i] >= 0 && own_m[i] == pre_own[i] && pre_ph[o] == 1 && in_id(o) == i) begin
          cnt_m[i]++;
          if (cnt_m[i] == 8) begin own_m[i] = -1; m_to[i] = 1'b1; cnt_m[i] = 0; end
        end else cnt_m[i] = 0;
      end
`endif
    end
  end

  function automatic logic [3:0] m_held();
    for (int i = 0; i < NL; i++) m_held[i] = (own_m[i] >= 0);
  endfunction
  function automatic logic [3:0] m_owner();
    for (int i = 0; i < NL; i++) m_owner[i] = (own_m[i] == 1);
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("c0_ack", c0_ack, m_ack[0]);
    chk("c0_err", c0_err, m_err[0]);
    chk("c1_ack", c1_ack, m_ack[1]);
    chk("c1_err", c1_err, m_err[1]);
    chk("lock_held", lock_held, m_held());
    chk("lock_owner", lock_owner, m_owner());
`ifdef LOCK_TIMEOUT_EN
    chk("lock_timeout", lock_timeout, m_to);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int c, input logic r, input logic o, input int id);
    if (c == 0) begin c0_req = r; c0_op = o; c0_id = 2'(id); end
    else        begin c1_req = r; c1_op = o; c1_id = 2'(id); end
  endtask

  task automatic issue(input int c, input logic o, input int id,
                       output int lat, output int ack_cyc, output logic err);
    int start;
    bit seen;
    @(negedge clk);
    drive(c, 1'b1, o, id);
    start = cyc;
    seen  = 0;
    err   = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if ((c == 0 ? c0_ack : c1_ack) === 1'b1) begin
        seen = 1;
        err  = (c == 0) ? c0_err : c1_err;
      end
    end
    ack_cyc = cyc;
    lat     = cyc - start;
    n_chk++;
    if (!seen) begin
      n_err++;
      $display("FAIL ack_wait core%0d: got no ack expected ack within 100 cycles", c);
    end
    drive(c, 1'b0, 1'b0, 0);
  endtask

  int   la, lb, ca, cb, cc, cd;
  logic ea, eb;
`ifdef LOCK_TIMEOUT_EN
  int   to_cyc = -1;
  always @(negedge clk) if (lock_timeout[0] === 1'b1) to_cyc = cyc;
`endif

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_held", lock_held, 4'b0000);
    chk("rst_owner", lock_owner, 4'b0000);
    chk("rst_acks", {c0_ack, c1_ack, c0_err, c1_err}, 4'b0000);
    rst_n = 1'b1;

    // c0 acquires lock 2
    issue(0, 1, 2, la, ca, ea);
    chk("t1_latency", la, 1);
    chk("t1_err", ea, 0);
    chk("t1_held", lock_held, 4'b0100);
    chk("t1_owner", lock_owner, 4'b0000);

    // c1 blocks on lock 2 until c0 releases it; handoff on the next edge
    fork
      issue(1, 1, 2, lb, cb, eb);
      begin repeat (3) @(negedge clk); issue(0, 0, 2, la, ca, ea); end
    join
    chk("t2_rel_err", ea, 0);
    chk("t2_acq_err", eb, 0);
    chk("t2_handoff_gap", cb - ca, 1);
    chk("t2_held", lock_held, 4'b0100);
    chk("t2_owner", lock_owner, 4'b0100);
    issue(1, 0, 2, la, ca, ea);
    chk("t2_c1_rel_err", ea, 0);

    // contended acquire of lock 1: c0 wins first (rr = core0)
    fork
      begin issue(0, 1, 1, la, ca, ea); repeat (2) @(negedge clk); issue(0, 0, 1, lb, cc, eb); end
      issue(1, 1, 1, lb, cb, eb);
    join
    chk("t3_c0_first_lat", la, 1);
    chk("t3_c1_after_rel", cb - cc, 1);
    chk("t3_owner", lock_owner, 4'b0010);
    issue(1, 0, 1, la, ca, ea);
    // second contended acquire: c1 now has priority
    fork
      issue(0, 1, 1, la, ca, ea);
      begin issue(1, 1, 1, lb, cb, eb); repeat (2) @(negedge clk); issue(1, 0, 1, lb, cd, eb); end
    join
    chk("t3_c1_wins_order", (cb < ca) ? 1 : 0, 1);
    chk("t3_c0_after_rel", ca - cd, 1);
    chk("t3_owner2", lock_owner, 4'b0000);
    chk("t3_held2", lock_held, 4'b0010);
    issue(0, 0, 1, la, ca, ea);

    // error cases
    issue(1, 0, 3, la, ca, ea);
    chk("t4_rel_free_err", ea, 1);
    chk("t4_held_a", lock_held, 4'b0000);
    issue(0, 1, 0, la, ca, ea);
    issue(0, 1, 0, la, ca, ea);
    chk("t4_reacq_err", ea, 1);
    chk("t4_held_b", lock_held, 4'b0001);
    issue(0, 0, 0, la, ca, ea);

    // different locks in parallel
    fork
      issue(0, 1, 0, la, ca, ea);
      issue(1, 1, 3, lb, cb, eb);
    join
    chk("t5_same_cycle", ca, cb);
    chk("t5_errs", {ea, eb}, 2'b00);
    chk("t5_held", lock_held, 4'b1001);
    chk("t5_owner", lock_owner, 4'b1000);
    issue(0, 0, 3, la, ca, ea);
    chk("t5_rel_other_err", ea, 1);
    chk("t5_held_kept", lock_held, 4'b1001);
    issue(1, 0, 3, la, ca, ea);
    issue(0, 0, 0, la, ca, ea);
    chk("t5_all_free", lock_held, 4'b0000);

`ifdef LOCK_TIMEOUT_EN
    // watchdog: c1 waits on lock 0 held by c0
    issue(0, 1, 0, la, ca, ea);
    cc = cyc + 1;
    issue(1, 1, 0, lb, cb, eb);
    chk("t6_timeout_cycle", to_cyc - cc, 9);
    chk("t6_grant_after_to", cb - to_cyc, 1);
    chk("t6_owner", lock_owner, 4'b0001);
    issue(0, 0, 0, la, ca, ea);
    chk("t6_stale_rel_err", ea, 1);
    issue(1, 0, 0, la, ca, ea);
    chk("t6_rel_ok", ea, 0);
`endif

    // reset in the middle of a wait
    issue(0, 1, 1, la, ca, ea);
    @(negedge clk);
    drive(1, 1, 1, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("t7_held", lock_held, 4'b0000);
    chk("t7_c1_ack", c1_ack, 0);
    drive(1, 0, 0, 0);
    rst_n = 1'b1;
    issue(1, 1, 1, lb, cb, eb);
    chk("t7_post_lat", lb, 1);
    chk("t7_post_owner", lock_owner, 4'b0010);
    issue(1, 0, 1, lb, cb, eb);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
